// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer (optional macro UART_TX_TWO_STOP_EN adds a second stop bit)
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  output logic       ready,
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_STOP2  = 3'd5
  } state_t;

  // Output-stage select codes
  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_STOP   = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_TWO_STOP_EN
  localparam state_t LAST_STOP = S_STOP2;
`else
  localparam state_t LAST_STOP = S_STOP;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic             busy_d, ser_en_d, frame_done_d;
  logic [1:0]       mux_sel_d;

  // Accept window: idle, or the final stop bit so frames can run back-to-back
  always_comb begin
    ready    = (state_q == S_IDLE) || (state_q == LAST_STOP);
    ser_load = DATA_VALID & ready;
  end

  // Next-state logic, then output decode from the next state so outputs move with the state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    busy_d       = 1'b0;
    mux_sel_d    = MUX_STOP;
    ser_en_d     = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ser_load) begin
          par_d   = PAR_EN;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = par_q ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
`ifdef UART_TX_TWO_STOP_EN
      S_STOP: begin
        state_d = S_STOP2;
      end
      S_STOP2: begin
        if (ser_load) begin
          par_d   = PAR_EN;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
`else
      S_STOP: begin
        if (ser_load) begin
          par_d   = PAR_EN;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START: begin
        busy_d    = 1'b1;
        mux_sel_d = MUX_START;
      end
      S_DATA: begin
        busy_d    = 1'b1;
        mux_sel_d = MUX_DATA;
        ser_en_d  = 1'b1;
      end
      S_PARITY: begin
        busy_d    = 1'b1;
        mux_sel_d = MUX_PARITY;
      end
      S_STOP: begin
        busy_d       = 1'b1;
        mux_sel_d    = MUX_STOP;
        frame_done_d = (LAST_STOP == S_STOP);
      end
      S_STOP2: begin
        busy_d       = 1'b1;
        mux_sel_d    = MUX_STOP;
        frame_done_d = (LAST_STOP == S_STOP2);
      end
      default: begin
        busy_d    = 1'b0;
        mux_sel_d = MUX_STOP;
      end
    endcase
  end

  // State, counter, latched parity enable and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      busy       <= 1'b0;
      mux_sel    <= MUX_STOP;
      ser_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      busy       <= busy_d;
      mux_sel    <= mux_sel_d;
      ser_en     <= ser_en_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

  localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       ready, ser_load, ser_en, busy, frame_done;
  logic [1:0] mux_sel;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .DATA_VALID(DATA_VALID), .PAR_EN(PAR_EN),
    .ready(ready), .ser_load(ser_load), .ser_en(ser_en),
    .mux_sel(mux_sel), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: {busy, mux_sel, ser_en, frame_done} for the current cycle plus the
  // remaining cycles of the frame in flight. Empty queue means a new frame may start.
  logic [4:0] cur = 5'b00100;
  logic [4:0] q[$];
  bit         mvalid = 0;

  function automatic logic [4:0] pk(input bit b, input logic [1:0] m, input bit se, input bit fd);
    return {b, m, se, fd};
  endfunction

  initial forever begin
    @(posedge CLK);
    if (RST) begin
      q.delete();
      cur    = pk(0, 2'b01, 0, 0);
      mvalid = 1;
    end else if (!mvalid) begin
      cur = cur;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (DATA_VALID) begin
      q.push_back(pk(1, 2'b00, 0, 0));
      for (int i = 0; i < W; i++) q.push_back(pk(1, 2'b10, 1, 0));
      if (PAR_EN) q.push_back(pk(1, 2'b11, 0, 0));
      for (int s = 0; s < NSTOP; s++) q.push_back(pk(1, 2'b01, 0, s == NSTOP - 1));
      cur = q.pop_front();
    end else begin
      cur = pk(0, 2'b01, 0, 0);
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge CLK);
    if (mvalid) begin
      check("busy", busy, cur[4]);
      check("mux_sel", mux_sel, cur[3:2]);
      check("ser_en", ser_en, cur[1]);
      check("frame_done", frame_done, cur[0]);
      check("ready", ready, q.size() == 0);
      check("ser_load", ser_load, DATA_VALID && (q.size() == 0));
    end
  end

  logic [4:0] lg[0:63];
  logic       lg_ld[0:63];
  int         li = 0;

  task automatic step(input bit dv, input bit pe, input bit rst);
    @(posedge CLK);
    #1;
    DATA_VALID = dv;
    PAR_EN     = pe;
    RST        = rst;
    @(negedge CLK);
    if (li < 64) begin
      lg[li]    = {busy, mux_sel, ser_en, frame_done};
      lg_ld[li] = ser_load;
      li++;
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  function automatic int busy_count();
    int c = 0;
    for (int i = 0; i < li; i++) if (lg[i][4]) c++;
    return c;
  endfunction

  // Hand rules for one frame accepted at log index 0
  task automatic analyze(input bit par, input string tag);
    int fl = 1 + W + int'(par) + NSTOP;
    check({tag, "_accept_load"}, lg_ld[0], 1);
    for (int i = 1; i <= fl; i++) begin
      logic [1:0] m;
      if (i == 1) m = 2'b00;
      else if (i <= W + 1) m = 2'b10;
      else if (par && i == W + 2) m = 2'b11;
      else m = 2'b01;
      check({tag, "_busy"}, lg[i][4], 1);
      check({tag, "_mux"}, lg[i][3:2], m);
      check({tag, "_ser_en"}, lg[i][1], (i >= 2 && i <= W + 1));
      check({tag, "_frame_done"}, lg[i][0], (i == fl));
      if (i < fl) check({tag, "_no_load"}, lg_ld[i], 0);
    end
    check({tag, "_end_busy"}, lg[fl + 1][4], 0);
    check({tag, "_end_mux"}, lg[fl + 1][3:2], 2'b01);
  endtask

  initial begin
    int fl, sec, fdc;

    step(0, 0, 1);
    step(0, 0, 0);
    check("rst_busy", busy, 0);
    check("rst_mux", mux_sel, 2'b01);
    check("rst_ser_en", ser_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ready", ready, 1);

    // Single frame, no parity
    li = 0;
    step(1, 0, 0);
    idle_steps(13);
    analyze(0, "t1");
    check("t1_len", busy_count(), (NSTOP == 2) ? 11 : 10);

    // Single frame with parity
    li = 0;
    step(1, 1, 0);
    idle_steps(13);
    analyze(1, "t2");
    check("t2_len", busy_count(), (NSTOP == 2) ? 12 : 11);
    sec = 0;
    for (int i = 0; i < li; i++) if (lg[i][1]) sec++;
    check("t2_ser_en_count", sec, 8);

    // Back-to-back frames
    li = 0;
    fl = 1 + W + NSTOP;
    for (int i = 0; i <= fl; i++) step(1, 0, 0);
    idle_steps(fl + 2);
    check("t3_second_load", lg_ld[fl], 1);
    check("t3_stop_mux", lg[fl][3:2], 2'b01);
    check("t3_start_mux", lg[fl + 1][3:2], 2'b00);
    check("t3_fd1", lg[fl][0], 1);
    check("t3_fd2", lg[2 * fl][0], 1);
    check("t3_len", busy_count(), (NSTOP == 2) ? 22 : 20);
    for (int i = 1; i <= 2 * fl; i++) check("t3_busy", lg[i][4], 1);
    check("t3_end_busy", lg[2 * fl + 1][4], 0);

    // Ignored request mid-frame and PAR_EN toggling
    li = 0;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    idle_steps(10);
    analyze(0, "t4");
    check("t4_ignored_load", lg_ld[5], 0);

    // Reset during the third data bit
    li = 0;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    check("t5_busy", lg[5][4], 0);
    check("t5_mux", lg[5][3:2], 2'b01);
    check("t5_ser_en", lg[5][1], 0);
    idle_steps(12);
    fdc = 0;
    for (int i = 0; i < li; i++) if (lg[i][0]) fdc++;
    check("t5_no_frame_done", fdc, 0);
    li = 0;
    step(1, 0, 0);
    idle_steps(13);
    analyze(0, "t5b");
    check("t5b_len", busy_count(), (NSTOP == 2) ? 11 : 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmit path.
- On accepting a transmit request, it drives the output-stage mux select and busy flag through the start, data, parity and stop phases.
- It also strobes the serializer's load and shift enables.
- One UART bit is sent per CLK cycle (CLK is the baud-rate clock); it sits between the register/host interface and the serializer, parity and output stage.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal 5..9).
- CNT_W, $clog2(DATA_WIDTH), width of the internal data-bit counter.

Ports:
- CLK  input  1  baud-rate clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- DATA_VALID  input  1  transmit request; a frame is accepted when DATA_VALID=1 and ready=1.
- PAR_EN  input  1  parity enable, sampled only on the accept cycle.
- ready  output  1  combinational; 1 in IDLE, or in the final stop cycle (back-to-back accept).
- ser_load  output  1  combinational; equals DATA_VALID & ready; the serializer captures the data word this cycle.
- ser_en  output  1  registered; 1 during DATA state, serializer shifts one bit per cycle.
- mux_sel  output  2  registered; output-stage select: 00=start bit(0), 01=stop bit(1), 10=serial data, 11=parity.
- busy  output  1  registered; 1 from START through the last STOP cycle.
- frame_done  output  1  registered; one-cycle pulse in the last stop cycle of each frame.

Behaviour:
- Reset (RST=1 at a rising edge) sets state=IDLE, busy=0, mux_sel=01, ser_en=0, frame_done=0, bit counter=0, latched parity enable=0.
- Reset mid-frame aborts the frame with no completion pulse; the line returns to idle-high through the output stage (busy=0).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Outputs: busy=0, mux_sel=01, ready=1.
  - If DATA_VALID=1: ser_load=1, PAR_EN is latched, and the next state is START.
- START: busy=1, mux_sel=00, lasts 1 cycle, next state DATA, counter cleared.
- DATA:
  - Outputs: busy=1, mux_sel=10, ser_en=1.
  - The counter increments each cycle. When counter==DATA_WIDTH-1, the counter is cleared and the next state is PARITY if the latched parity enable is set, else STOP.
- PARITY: busy=1, mux_sel=11, lasts 1 cycle, next state STOP.
- STOP:
  - Outputs: busy=1, mux_sel=01, frame_done=1, ready=1.
  - If DATA_VALID=1: ser_load=1, PAR_EN is latched, next state START (no idle gap).
  - Otherwise the next state is IDLE.
- Frame length is 1+DATA_WIDTH+P+1 cycles, where P is the latched parity enable.
- State-to-output decode is registered: outputs change on the same edge as the state.
- DATA_VALID while ready=0 is ignored. No queuing is done; the requester must hold DATA_VALID until it sees ser_load.
- PAR_EN changes mid-frame have no effect.
- Unreachable state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- When defined:
  - A STOP2 state follows STOP. STOP and STOP2 both have busy=1 and mux_sel=01.
  - ready, frame_done and back-to-back accept apply to STOP2 only; STOP always goes to STOP2.
  - Frame length is 1+DATA_WIDTH+P+2 cycles.
- When undefined: a single stop bit, exactly as specified above.

Test Plan:
- Reset, then DATA_VALID=1 for 1 cycle with PAR_EN=0 (DATA_WIDTH=8):
  - ser_load=1 on the accept cycle.
  - Next 10 cycles: busy=1 with mux_sel sequence 00, 10 ×8, 01.
  - frame_done=1 on cycle 10, then busy=0 and mux_sel=01.
- Same stimulus with PAR_EN=1: busy for 11 cycles with mux_sel 00, 10 ×8, 11, 01; ser_en=1 for exactly 8 cycles.
- DATA_VALID held high for 2 frames (PAR_EN=0):
  - The second ser_load coincides with the first frame's stop cycle.
  - mux_sel goes 01 then 00 on consecutive cycles; busy stays 1 for 20 cycles.
- DATA_VALID pulsed during the 4th DATA cycle, and PAR_EN toggled mid-frame: no ser_load, frame length and sequence unchanged.
- RST=1 during the 3rd DATA cycle:
  - Next edge gives busy=0, mux_sel=01, ser_en=0, and frame_done never pulses.
  - A new DATA_VALID is then accepted and yields a full 10-cycle frame.
- UART_TX_TWO_STOP_EN defined, PAR_EN=1: busy for 12 cycles with two 01 cycles at the end; frame_done only in the 12th cycle.
